// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for 8 requesters with a one-hot grant decoded from a registered index,
// a bounded hold time and a mandatory dead cycle between consecutive owners.
module rr_decode_arbiter #(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {StIdle, StGrant} state_e;

  localparam logic [7:0] HoldLast = 8'(HOLD_MAX - 1);

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] hcnt_q, hcnt_d;
  logic [2:0] idx_q, idx_d;
  logic       valid_q, valid_d;
  logic [7:0] gnt_q, gnt_d;
  logic       timeout_q, timeout_d;

  logic       found;
  logic [2:0] winner;
  logic [2:0] cand;
  logic       hold_hit;
  logic       end_grant;

  // Scan from the priority pointer upwards, wrapping modulo 8.
  always_comb begin
    found  = 1'b0;
    winner = 3'd0;
    cand   = 3'd0;
    for (int k = 0; k < 8; k++) begin
      cand = ptr_q + 3'(k);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign hold_hit  = (hcnt_q == HoldLast);
  assign end_grant = done | ~req[idx_q] | hold_hit;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hcnt_d    = hcnt_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en && found) begin
          idx_d   = winner;
          valid_d = 1'b1;
          hcnt_d  = 8'd0;
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (end_grant) begin
          valid_d   = 1'b0;
          state_d   = StIdle;
          ptr_d     = idx_q + 3'd1;
          hcnt_d    = 8'd0;
          // Flag only revocations caused purely by the hold limit.
          timeout_d = hold_hit & ~done & req[idx_q];
        end else begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    gnt_d = valid_d ? (8'd1 << idx_d) : 8'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ptr_q     <= 3'd0;
      hcnt_q    <= 8'd0;
      idx_q     <= 3'd0;
      valid_q   <= 1'b0;
      gnt_q     <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hcnt_q    <= hcnt_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      gnt_q     <= gnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;
  assign timeout   = timeout_q;

endmodule
